regfile_bus_arbiter: RTL and testbench

//  Shares one regfile bus port (addr/chip_select/write_en/read_en/write_data/read_data/data_valid)

---
 rtl/regfile_bus_arbiter.sv | 157 +++++++++++++++
 tb/tb_regfile_bus_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_bus_arbiter.sv
// Round-robin arbiter sharing one regfile bus port among NUM_REQ requesters, one 3-cycle access at a time.
// Optional owner lock for atomic sequences is compiled in when REGARB_LOCK_EN is defined.
module regfile_bus_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 32,
   parameter int LOCK_MAX = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_write,
   input  logic [NUM_REQ-1:0]        req_lock,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        req_ack,
   output logic [DATA_W-1:0]         req_rdata,
   output logic [2:0]                gnt_id,
   output logic                      busy,
   output logic [ADDR_W-1:0]         addr,
   output logic                      chip_select,
   output logic                      write_en,
   output logic                      read_en,
   output logic [DATA_W-1:0]         write_data,
   input  logic [DATA_W-1:0]         read_data,
   input  logic                      data_valid
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, ACK = 2'd2} state_t;

   state_t                         state, state_nxt;
   logic [NUM_REQ-1:0][ADDR_W-1:0] addr_arr;
   logic [NUM_REQ-1:0][DATA_W-1:0] wdata_arr;
   logic [IDX_W-1:0]               gnt_q, gnt_nxt, rr_ptr, rr_nxt, win_idx, nxt_owner;
   logic [IDX_W:0]                 cand;
   logic                           win_found, wr_q, wr_nxt, hold_ptr;
   logic [ADDR_W-1:0]              addr_nxt;
   logic [DATA_W-1:0]              wdata_nxt, rdata_nxt;
   logic [NUM_REQ-1:0]             ack_nxt;
   logic                           cs_nxt, we_nxt, re_nxt, busy_nxt;

   assign addr_arr  = req_addr;
   assign wdata_arr = req_wdata;
   assign gnt_id    = 3'(gnt_q);
   assign nxt_owner = (gnt_q == IDX_W'(NUM_REQ-1)) ? '0 : gnt_q + IDX_W'(1);

   // First requester at or after rr_ptr, wrapping NUM_REQ-1 -> 0.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
         if (cand >= (IDX_W+1)'(NUM_REQ))
            cand = cand - (IDX_W+1)'(NUM_REQ);
         if (!win_found && req_valid[cand[IDX_W-1:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[IDX_W-1:0];
         end
      end
   end

`ifdef REGARB_LOCK_EN
   localparam int LCNT_W = $clog2(LOCK_MAX) + 1;
   logic [LCNT_W-1:0] lock_cnt;

   // Owner keeps the pointer while locking, bounded so others are not starved.
   assign hold_ptr = req_lock[gnt_q] && (lock_cnt < LCNT_W'(LOCK_MAX-1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         lock_cnt <= '0;
      else if (state == IDLE && win_found && win_idx != gnt_q)
         lock_cnt <= '0;
      else if (state == ACK)
         lock_cnt <= hold_ptr ? lock_cnt + LCNT_W'(1) : '0;
   end
`else
   localparam int unused_lock_max = LOCK_MAX;
   logic unused_lock;
   assign unused_lock = ^req_lock;
   assign hold_ptr    = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      gnt_nxt   = gnt_q;
      rr_nxt    = rr_ptr;
      wr_nxt    = wr_q;
      addr_nxt  = addr;
      wdata_nxt = write_data;
      rdata_nxt = req_rdata;
      cs_nxt    = 1'b0;
      we_nxt    = 1'b0;
      re_nxt    = 1'b0;
      ack_nxt   = '0;
      busy_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (win_found) begin
               state_nxt = ACCESS;
               gnt_nxt   = win_idx;
               wr_nxt    = req_write[win_idx];
               addr_nxt  = addr_arr[win_idx];
               wdata_nxt = wdata_arr[win_idx];
               cs_nxt    = 1'b1;
               we_nxt    = req_write[win_idx];
               re_nxt    = ~req_write[win_idx];
               busy_nxt  = 1'b1;
            end
         end
         ACCESS: begin
            state_nxt        = ACK;
            busy_nxt         = 1'b1;
            ack_nxt[gnt_q]   = 1'b1;
            if (!wr_q)
               rdata_nxt = data_valid ? read_data : '0;
         end
         ACK: begin
            state_nxt = IDLE;
            rr_nxt    = hold_ptr ? gnt_q : nxt_owner;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         gnt_q       <= '0;
         rr_ptr      <= '0;
         wr_q        <= 1'b0;
         addr        <= '0;
         write_data  <= '0;
         req_rdata   <= '0;
         chip_select <= 1'b0;
         write_en    <= 1'b0;
         read_en     <= 1'b0;
         req_ack     <= '0;
         busy        <= 1'b0;
      end else begin
         state       <= state_nxt;
         gnt_q       <= gnt_nxt;
         rr_ptr      <= rr_nxt;
         wr_q        <= wr_nxt;
         addr        <= addr_nxt;
         write_data  <= wdata_nxt;
         req_rdata   <= rdata_nxt;
         chip_select <= cs_nxt;
         write_en    <= we_nxt;
         read_en     <= re_nxt;
         req_ack     <= ack_nxt;
         busy        <= busy_nxt;
      end
   end
endmodule

// File: tb/tb_regfile_bus_arbiter.sv
// Bench for regfile_bus_arbiter: transaction-timing model checked every cycle plus directed literal checks.
module tb_regfile_bus_arbiter;
   localparam int N = 4, AW = 8, DW = 32;
`ifdef REGARB_LOCK_EN
   localparam int LOCK_MAX = 4;
`endif

   logic            clk = 1'b0, rst_n = 1'b0;
   logic [N-1:0]    req_valid = '0, req_write = '0, req_lock = '0;
   logic [N*AW-1:0] req_addr = '0;
   logic [N*DW-1:0] req_wdata = '0;
   logic [N-1:0]    req_ack;
   logic [DW-1:0]   req_rdata, write_data, read_data;
   logic [2:0]      gnt_id;
   logic            busy, chip_select, write_en, read_en, data_valid;
   logic [AW-1:0]   addr;
   logic            dv_en = 1'b1;
   logic [DW-1:0]   mem [256];

   assign read_data  = mem[addr];
   assign data_valid = dv_en;

   always #5 clk = ~clk;

   regfile_bus_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(4)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
      .req_lock(req_lock), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ack(req_ack), .req_rdata(req_rdata), .gnt_id(gnt_id), .busy(busy),
      .addr(addr), .chip_select(chip_select), .write_en(write_en), .read_en(read_en),
      .write_data(write_data), .read_data(read_data), .data_valid(data_valid));

   int n_chk = 0, n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic bit_of(input logic [N-1:0] v, input int i);
      return |(v & (N'(1) << i));
   endfunction

   // Model: a grant at edge g puts strobes on the bus after g, the ack after g+1,
   // and the next arbitration happens no earlier than edge g+3.
   int cyc = 0, last_g = -100, owner = 0, ptr = 0, lcnt = 0;
   logic          m_wr = 1'b0;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_wd = '0, m_rdata = '0;
   int ack_ids[$], ack_cyc[$];

   initial begin : model
      int w;
      bit found;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            last_g = -100; owner = 0; ptr = 0; lcnt = 0;
            m_wr = 1'b0; m_addr = '0; m_wd = '0; m_rdata = '0;
         end else begin
            cyc++;
            if (cyc - last_g == 1 && !m_wr)
               m_rdata = dv_en ? mem[m_addr] : '0;
            if (cyc - last_g == 2) begin
`ifdef REGARB_LOCK_EN
               if (bit_of(req_lock, owner) && lcnt < LOCK_MAX-1) begin
                  ptr = owner; lcnt++;
               end else begin
                  ptr = (owner + 1) % N; lcnt = 0;
               end
`else
               ptr = (owner + 1) % N;
`endif
            end
            if (cyc - last_g >= 3) begin
               found = 0; w = 0;
               for (int k = 0; k < N; k++)
                  if (!found && bit_of(req_valid, (ptr + k) % N)) begin
                     found = 1; w = (ptr + k) % N;
                  end
               if (found) begin
                  if (w != owner) lcnt = 0;
                  owner  = w;
                  last_g = cyc;
                  m_wr   = bit_of(req_write, w);
                  m_addr = AW'(req_addr >> (w*AW));
                  m_wd   = DW'(req_wdata >> (w*DW));
               end
            end
         end
      end
   end

   initial begin : compare
      int d;
      logic [N-1:0] e_ack;
      forever begin
         @(negedge clk);
         d = cyc - last_g;
         e_ack = (d == 1) ? (N'(1) << owner) : '0;
         chk("m_cs",    64'(chip_select), 64'(d == 0));
         chk("m_we",    64'(write_en),    64'(d == 0 && m_wr));
         chk("m_re",    64'(read_en),     64'(d == 0 && !m_wr));
         chk("m_ack",   64'(req_ack),     64'(e_ack));
         chk("m_busy",  64'(busy),        64'(d == 0 || d == 1));
         chk("m_gnt",   64'(gnt_id),      64'(owner));
         chk("m_addr",  64'(addr),        64'(m_addr));
         chk("m_wdata", 64'(write_data),  64'(m_wd));
         chk("m_rdata", 64'(req_rdata),   64'(m_rdata));
         for (int i = 0; i < N; i++)
            if (bit_of(req_ack, i)) begin
               ack_ids.push_back(i);
               ack_cyc.push_back(cyc);
            end
      end
   end

   task automatic tick();
      @(posedge clk); #2;
   endtask

   task automatic issue(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_write = wr ? (req_write | (N'(1) << i)) : (req_write & ~(N'(1) << i));
      req_addr  = (req_addr & ~((N*AW)'({AW{1'b1}}) << (i*AW))) | ((N*AW)'(a) << (i*AW));
      req_wdata = (req_wdata & ~((N*DW)'({DW{1'b1}}) << (i*DW))) | ((N*DW)'(d) << (i*DW));
      req_valid = req_valid | (N'(1) << i);
   endtask

   // Lone request from an idle arbiter: literal checks on the strobe and ack cycles.
   task automatic one_shot(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      tick();
      issue(i, wr, a, d);
      @(negedge clk);
      chk("os_idle_cs", 64'(chip_select), 64'h0);
      @(negedge clk);
      chk("os_cs",   64'(chip_select), 64'h1);
      chk("os_we",   64'(write_en),    64'(wr));
      chk("os_re",   64'(read_en),     64'(!wr));
      chk("os_addr", 64'(addr),        64'(a));
      chk("os_gnt",  64'(gnt_id),      64'(i));
      if (wr) chk("os_wdata", 64'(write_data), 64'(d));
      @(negedge clk);
      chk("os_ack",  64'(req_ack),     64'(N'(1) << i));
      chk("os_strobes_off", 64'({chip_select, write_en, read_en}), 64'h0);
      tick();
      req_valid = '0;
      tick();
   endtask

   task automatic wait_acks(input int n, input int budget);
      int t = 0;
      while (ack_ids.size() < n && t < budget) begin
         @(negedge clk); #1;
         t++;
      end
      chk("ack_count", 64'(ack_ids.size()), 64'(n));
   endtask

   task automatic do_reset();
      @(negedge clk); #1;
      rst_n = 1'b0; req_valid = '0; req_lock = '0;
      #2;
      chk("rst_busy", 64'(busy), 64'h0);
      @(negedge clk); #1;
      rst_n = 1'b1;
      tick();
      ack_ids.delete(); ack_cyc.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int exp_fair[$] = '{0, 1, 2, 3, 0};
      int exp_wrap[$] = '{0, 1};
`ifdef REGARB_LOCK_EN
      int exp_lock[$] = '{1, 1, 1, 1, 3};
`else
      int exp_lock[$] = '{1, 3, 1, 3};
`endif
      for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i);
      mem[8'h14] = 32'h0000_AA55;
      mem[8'h20] = 32'h0000_1234;

      #3;
      chk("rst0_outs", 64'({chip_select, write_en, read_en, busy, req_ack, gnt_id}), 64'h0);
      chk("rst0_rdata", 64'(req_rdata), 64'h0);
      @(negedge clk); #1 rst_n = 1'b1;
      tick(); tick();

      one_shot(0, 1'b1, 8'h00, 32'h5);
      dv_en = 1'b0;
      one_shot(1, 1'b0, 8'h20, 32'h0);
      chk("rd_no_valid", 64'(req_rdata), 64'h0);
      dv_en = 1'b1;
      one_shot(2, 1'b0, 8'h14, 32'h0);
      chk("rd_aa55", 64'(req_rdata), 64'hAA55);
      one_shot(0, 1'b1, 8'h30, 32'hDEAD_BEEF);
      chk("wr_keeps_rdata", 64'(req_rdata), 64'hAA55);

      // Reset while a read by requester 1 is on the bus.
      tick();
      issue(1, 1'b0, 8'h14, 32'h0);
      @(negedge clk); @(negedge clk);
      chk("pre_rst_cs", 64'(chip_select), 64'h1);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_strobes", 64'({chip_select, write_en, read_en, busy}), 64'h0);
      chk("mid_rst_ack",     64'(req_ack),   64'h0);
      chk("mid_rst_gnt",     64'(gnt_id),    64'h0);
      chk("mid_rst_rdata",   64'(req_rdata), 64'h0);
      chk("mid_rst_addr",    64'(addr),      64'h0);
      req_valid = '0;
      ack_ids.delete(); ack_cyc.delete();
      @(negedge clk); #1 rst_n = 1'b1;
      repeat (4) tick();
      chk("no_ack_after_rst", 64'(ack_ids.size()), 64'h0);

      // Fairness with all four requesting.
      do_reset();
      for (int i = 0; i < N; i++) issue(i, 1'b1, AW'(8'h40 + i), 32'hC0DE_0000 + 32'(i));
      wait_acks(5, 40);
      tick(); req_valid = '0;
      for (int k = 0; k < 5 && k < ack_ids.size(); k++)
         chk("fair_order", 64'(ack_ids[k]), 64'(exp_fair[k]));
      for (int k = 1; k < 5 && k < ack_cyc.size(); k++)
         chk("fair_gap", 64'(ack_cyc[k] - ack_cyc[k-1]), 64'h3);

      // Pointer wrap: requester 2 served last, then 0 and 1 compete.
      do_reset();
      one_shot(2, 1'b1, 8'h50, 32'h7);
      ack_ids.delete(); ack_cyc.delete();
      issue(0, 1'b0, 8'h14, 32'h0);
      issue(1, 1'b1, 8'h51, 32'h8);
      wait_acks(2, 30);
      tick(); req_valid = '0;
      for (int k = 0; k < 2 && k < ack_ids.size(); k++)
         chk("wrap_order", 64'(ack_ids[k]), 64'(exp_wrap[k]));

      // Locked owner 1 against pending requester 3.
      do_reset();
      req_lock = 4'b0010;
      issue(1, 1'b0, 8'h14, 32'h0);
      issue(3, 1'b1, 8'h60, 32'h9);
      wait_acks(exp_lock.size(), 60);
      tick(); req_valid = '0; req_lock = '0;
      for (int k = 0; k < exp_lock.size() && k < ack_ids.size(); k++)
         chk("lock_order", 64'(ack_ids[k]), 64'(exp_lock[k]));

      repeat (4) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
